ec_point_unit: RTL and testbench
================================

// Module: ec_point_unit
// PURPOSE
//   Sequential GF(2^M) elliptic-curve point unit, curve y^2 + xy = x^3 + a*x^2 + b.
//   Computes 2P (op=0) or P+Q (op=1) in affine coords, with valid/ready handshakes.
//   Shares one bit-serial multiplier; inversion is Fermat (x^(2^M-2)).
//   Feeds the scalar-multiply controller. Replaces the fixed 7-bit combinational doubler.
// PARAMETERS
//   M       7      field width in bits; legal range is M >= 3
//   POLY    7'h03  low M coeffs of the irreducible polynomial; x^M implied (x^7+x+1)
//   CURVE_A 1      curve coefficient a; legal values are 0 and 1
// PORTS
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous, active-high reset
//   in_valid   in   1    operands valid
//   in_ready   out  1    unit idle, can accept
//   op         in   1    0 = double point_a; 1 = point_a + point_b
//   point_a    in   2M   {y1, x1}
//   point_b    in   2M   {y2, x2}; ignored when op=0
//   out_valid  out  1    result valid
//   out_ready  in   1    consumer accepts result
//   result     out  2M   {y3, x3}; (0,0) encodes point at infinity
// BEHAVIOUR
//   Reset: in_ready=1, out_valid=0, result=0; FSM enters IDLE. Internal regs are cleared.
//   Accept: an accept occurs on an edge with in_valid & in_ready. Inputs are latched then.
//     in_ready is high only in IDLE.
//   States: IDLE -> {FAST | INV} ; INV -> LAMBDA -> YMUL -> DONE ; FAST -> DONE ;
//     DONE -> IDLE on out_ready.
//   Denominator d and numerator n:
//     op=0: d=x1, n=y1.
//     op=1: d=x1^x2, n=y1^y2.
//   Fast paths, taken in FAST state, with result computed combinationally from latched inputs:
//     op=0, x1==0: result 0.
//     op=1, point_a==0: result point_b.
//     op=1, point_b==0: result point_a.
//     op=1, x1==x2, y1!=y2: result 0 (Q = -P).
//     op=1, P==Q: handled as op=0 through the full path.
//   Fast-path latency: out_valid is high 2 edges after accept.
//   Multiplier:
//     MSB-first shift-and-add with reduction by POLY.
//     Exactly M cycles per product. Squaring is combinational (operand prep, 0 cycles).
//   INV: t=d^2, acc=t; then for i=2..M-1: t=t^2, acc=acc*t. That is M-2 products; acc=d^-1.
//   LAMBDA: lam = n*acc, plus x1 when op=0. 1 product.
//     x3 = lam^2 ^ lam ^ CURVE_A, plus x1^x2 when op=1.
//   YMUL: y3 = lam*(x1^x3) ^ x3 ^ y1. 1 product.
//   Full-path latency: out_valid high M*M+1 edges after accept (M=7: 50).
//   DONE: result and out_valid are registered and held stable until out_ready.
//     IDLE is re-entered on the out_ready edge; a new accept can occur on the next edge.
//     No input is accepted while out_valid=1.
//   Arithmetic: all addition is XOR. Widths are exact M bits; no carries.
//   rst mid-operation: immediate abort to reset values; no result is emitted.
//   in_valid during busy: ignored; the source must hold it until in_ready.
// TESTING
//   Double (x=01,y=00), M=7, a=1 -> result {y=01,x=01} after exactly 50 cycles.
//   Double (x=02,y=00) -> {y=0D,x=07}; exercises inversion of 02.
//   Double (x=01,y=01) -> {y=00,x=01}. Double (x=00,y=5A) -> 0 in 2 cycles (fast path).
//   Add P=(02,00), Q=(02,02) -> 0 (negation fast path). Add P+0 -> P.
//     Add P+P -> same as double P.
//   Hold out_ready=0 for 20 cycles: result stays stable and in_ready=0. Then one pulse
//     -> in_ready=1 next cycle.
//   Assert rst at cycle 25 of a full op -> out_valid never rises. Next op completes correctly.

Source files
------------

// File: rtl/ec_point_unit.sv
`timescale 1ns/1ps
// ec_point_unit: sequential GF(2^M) affine point unit for y^2 + xy = x^3 + a*x^2 + b.
// Computes 2P (op=0) or P+Q (op=1) with one shared bit-serial multiplier and
// Fermat inversion. Trivial cases (infinity operands, x=0 doubling, Q=-P)
// resolve through a short FAST state.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready operand handshake; in_ready is high only while idle
//   op                  0 = double point_a, 1 = point_a + point_b
//   point_a, point_b    {y, x} operands, M bits per coordinate
//   out_valid/out_ready result handshake; result held stable until accepted
//   result              {y3, x3}; (0,0) encodes the point at infinity
module ec_point_unit #(
  parameter int unsigned    M       = 7,
  parameter logic [M-1:0]   POLY    = M'(3),
  parameter int unsigned    CURVE_A = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           op,
  input  logic [2*M-1:0] point_a,
  input  logic [2*M-1:0] point_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*M-1:0] result
);

  localparam int unsigned CW       = $clog2(M);
  localparam int unsigned INV_LAST = M - 3;

  typedef enum logic [2:0] {
    S_IDLE, S_FAST, S_INV, S_LAMBDA, S_YMUL, S_DONE
  } state_t;

  // Field squaring: spread bits to even positions, then fold x^M back as POLY.
  function automatic logic [M-1:0] gf_sq(input logic [M-1:0] x);
    logic [2*M-2:0] w;
    w = '0;
    for (int i = 0; i < int'(M); i++) w[2*i] = x[i];
    for (int i = 2*int'(M) - 2; i >= int'(M); i--) begin
      if (w[i]) begin
        w[i] = 1'b0;
        w[i-int'(M) +: M] = w[i-int'(M) +: M] ^ POLY;
      end
    end
    return w[M-1:0];
  endfunction

  // One MSB-first shift-and-add step: p = p*x mod poly, plus a when the bit is set.
  function automatic logic [M-1:0] gf_step(input logic [M-1:0] p,
                                           input logic [M-1:0] a,
                                           input logic         b);
    logic [M-1:0] s;
    s = {p[M-2:0], 1'b0} ^ (p[M-1] ? POLY : '0);
    return s ^ (b ? a : '0);
  endfunction

  state_t         r_state, w_state_nxt;
  logic           r_op, r_dbl;
  logic [M-1:0]   r_x1, r_y1, r_x2, r_y2;
  logic [M-1:0]   r_n, r_acc, r_t, r_p, r_x3, r_y3;
  logic [CW-1:0]  r_bit, r_k;
  logic           r_in_ready, r_out_valid;
  logic [2*M-1:0] r_result;

  logic [M-1:0]   w_x1, w_y1, w_x2, w_y2, w_d, w_n, w_d_sq;
  logic           w_a_zero, w_b_zero, w_same, w_dbl, w_fast;
  logic [M-1:0]   w_prod_nxt, w_lam, w_x3, w_y3;
  logic           w_last;
  logic [2*M-1:0] w_fast_res;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;

  // Operand decode at accept: P==Q folds into doubling.
  assign w_x1     = point_a[M-1:0];
  assign w_y1     = point_a[2*M-1:M];
  assign w_x2     = point_b[M-1:0];
  assign w_y2     = point_b[2*M-1:M];
  assign w_a_zero = (point_a == '0);
  assign w_b_zero = (point_b == '0);
  assign w_same   = (point_a == point_b);
  assign w_dbl    = !op || w_same;
  assign w_fast   = w_dbl ? (w_x1 == '0)
                          : (w_a_zero || w_b_zero || (w_x1 == w_x2));
  assign w_d      = w_dbl ? w_x1 : (w_x1 ^ w_x2);
  assign w_n      = w_dbl ? w_y1 : (w_y1 ^ w_y2);
  assign w_d_sq   = gf_sq(w_d);

  // Shared multiplier: r_acc * r_t, one bit of r_t per cycle.
  assign w_prod_nxt = gf_step(r_p, r_acc, r_t[r_bit]);
  assign w_last     = (r_bit == '0);
  assign w_lam      = w_prod_nxt ^ (r_dbl ? r_x1 : '0);
  assign w_x3       = gf_sq(w_lam) ^ w_lam ^ M'(CURVE_A) ^ (r_dbl ? '0 : (r_x1 ^ r_x2));
  assign w_y3       = w_prod_nxt ^ r_x3 ^ r_y1;

  // Fast-path result from latched operands; any other fast case is infinity.
  always_comb begin
    w_fast_res = '0;
    if (r_op && ({r_y1, r_x1} == '0))      w_fast_res = {r_y2, r_x2};
    else if (r_op && ({r_y2, r_x2} == '0)) w_fast_res = {r_y1, r_x1};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (in_valid) w_state_nxt = w_fast ? S_FAST : S_INV;
      S_FAST:   w_state_nxt = S_DONE;
      S_INV:    if (w_last && (r_k == CW'(INV_LAST))) w_state_nxt = S_LAMBDA;
      S_LAMBDA: if (w_last) w_state_nxt = S_YMUL;
      S_YMUL:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:   if (r_out_valid && out_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_in_ready <= 1'b1;
    else     r_in_ready <= (w_state_nxt == S_IDLE);
  end

  // Datapath: operand latch, inversion chain, lambda and y3 products, output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op <= 1'b0;  r_dbl <= 1'b0;
      r_x1 <= '0;    r_y1 <= '0;   r_x2 <= '0;  r_y2 <= '0;
      r_n  <= '0;    r_acc <= '0;  r_t <= '0;   r_p <= '0;
      r_x3 <= '0;    r_y3 <= '0;   r_bit <= '0; r_k <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_op  <= op;     r_dbl <= w_dbl;
          r_x1  <= w_x1;   r_y1  <= w_y1;
          r_x2  <= w_x2;   r_y2  <= w_y2;
          r_n   <= w_n;
          // acc = d^2 and t = d^4 ready for the first inversion product.
          r_acc <= w_d_sq;
          r_t   <= gf_sq(w_d_sq);
          r_p   <= '0;
          r_bit <= CW'(M - 1);
          r_k   <= '0;
        end
        S_FAST: {r_y3, r_x3} <= w_fast_res;
        S_INV: begin
          r_p   <= w_prod_nxt;
          r_bit <= r_bit - CW'(1);
          if (w_last) begin
            r_p   <= '0;
            r_bit <= CW'(M - 1);
            r_acc <= w_prod_nxt;
            r_k   <= r_k + CW'(1);
            // After the final product acc = d^-1; next multiply is n*acc.
            r_t   <= (r_k == CW'(INV_LAST)) ? r_n : gf_sq(r_t);
          end
        end
        S_LAMBDA: begin
          r_p   <= w_prod_nxt;
          r_bit <= r_bit - CW'(1);
          if (w_last) begin
            r_p   <= '0;
            r_bit <= CW'(M - 1);
            r_acc <= w_lam;
            r_t   <= r_x1 ^ w_x3;
            r_x3  <= w_x3;
          end
        end
        S_YMUL: begin
          r_p   <= w_prod_nxt;
          r_bit <= r_bit - CW'(1);
          if (w_last) r_y3 <= w_y3;
        end
        S_DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_result    <= {r_y3, r_x3};
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ec_point_unit.sv
`timescale 1ns/1ps
// Scoreboard bench for ec_point_unit (M=7, x^7+x+1, a=1).
module tb_ec_point_unit;

  localparam int M    = 7;
  localparam int MASK = 127;
  localparam int FULL = M*M + 1;
  localparam int FAST = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op = 1'b0;
  logic [13:0] point_a = '0;
  logic [13:0] point_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [13:0] result;

  ec_point_unit #(.M(7), .POLY(7'h03), .CURVE_A(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .point_a(point_a), .point_b(point_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct { int res; int acc; int lat; } exp_t;
  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   manual_mode = 1'b0;
  bit   manual_rdy  = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  // Consumer: random backpressure unless a test takes manual control.
  always @(posedge clk) begin
    #2;
    out_ready = manual_mode ? manual_rdy : ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // ---------------- reference model (plain field arithmetic) ----------------
  function automatic int gmul(input int a, input int b);
    int p = 0;
    for (int i = 0; i < M; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
    for (int i = 2*M - 2; i >= M; i--) if (((p >> i) & 1) != 0) p = p ^ (32'h83 << (i - M));
    return p & MASK;
  endfunction

  function automatic int ginv(input int d);
    for (int x = 1; x <= MASK; x++) if (gmul(x, d) == 1) return x;
    return 0;
  endfunction

  function automatic int pt(input int y, input int x);
    return ((y & MASK) << M) | (x & MASK);
  endfunction

  function automatic int ref_dbl(input int p);
    int x1 = p & MASK, y1 = p >> M, lam, x3, y3;
    if (x1 == 0) return 0;
    lam = x1 ^ gmul(y1, ginv(x1));
    x3  = gmul(lam, lam) ^ lam ^ 1;
    y3  = gmul(x1, x1) ^ gmul(lam ^ 1, x3);
    return pt(y3, x3);
  endfunction

  function automatic int ref_op(input int o, input int a, input int b);
    int x1 = a & MASK, y1 = a >> M, x2 = b & MASK, y2 = b >> M, lam, x3, y3;
    if (o == 0) return ref_dbl(a);
    if (a == 0) return b;
    if (b == 0) return a;
    if (x1 == x2) return (y1 == y2) ? ref_dbl(a) : 0;
    lam = gmul(y1 ^ y2, ginv(x1 ^ x2));
    x3  = gmul(lam, lam) ^ lam ^ x1 ^ x2 ^ 1;
    y3  = gmul(lam, x1 ^ x3) ^ x3 ^ y1;
    return pt(y3, x3);
  endfunction

  function automatic int ref_lat(input int o, input int a, input int b);
    int x1 = a & MASK, x2 = b & MASK;
    if (o == 0 || a == b) return (x1 == 0) ? FAST : FULL;
    return (a == 0 || b == 0 || x1 == x2) ? FAST : FULL;
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input int o, input int a, input int b, input int res, input int lat);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) begin check("accept_timeout", 0, 1); return; end
    op = o[0]; point_a = 14'(a); point_b = 14'(b); in_valid = 1'b1;
    @(posedge clk); #1;
    q.push_back('{res: res, acc: cyc, lat: lat});
    in_valid = 1'b0;
  endtask

  // ---------------- monitor ----------------
  bit          prev_v, prev_hs;
  logic [13:0] prev_res;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_v = 1'b0; prev_hs = 1'b0;
    end else begin
      if (out_valid) check("in_ready_while_valid", int'(in_ready), 0);
      if (prev_hs) begin
        check("valid_drop_after_accept", int'(out_valid), 0);
      end else if (prev_v) begin
        check("valid_held", int'(out_valid), 1);
        check("result_held", int'(result), int'(prev_res));
      end else if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_result", int'(result), -1);
        end else begin
          e = q.pop_front();
          check("result", int'(result), e.res);
          check("latency", cyc - e.acc, e.lat);
        end
      end
      prev_v   = out_valid;
      prev_res = result;
      prev_hs  = out_valid && out_ready;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int o, a, b, n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_result", int'(result), 0);

    // Directed vectors with hand-derived results.
    issue(0, pt(8'h00, 8'h01), 0, pt(8'h01, 8'h01), FULL);
    issue(0, pt(8'h00, 8'h02), 0, pt(8'h0D, 8'h07), FULL);
    issue(0, pt(8'h01, 8'h01), 0, pt(8'h00, 8'h01), FULL);
    issue(0, pt(8'h5A, 8'h00), 0, 0, FAST);
    issue(1, pt(8'h00, 8'h02), pt(8'h02, 8'h02), 0, FAST);
    issue(1, pt(8'h00, 8'h02), 0, pt(8'h00, 8'h02), FAST);
    issue(1, 0, pt(8'h33, 8'h15), pt(8'h33, 8'h15), FAST);
    issue(1, pt(8'h00, 8'h02), pt(8'h00, 8'h02), pt(8'h0D, 8'h07), FULL);

    // Backpressure: result held for 20 cycles, then a single-cycle accept.
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 400) begin @(negedge clk); n++; end
    manual_mode = 1'b1; manual_rdy = 1'b0;
    issue(0, pt(8'h00, 8'h01), 0, pt(8'h01, 8'h01), FULL);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    check("hold_valid_seen", int'(out_valid), 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_result", int'(result), pt(8'h01, 8'h01));
      check("hold_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    manual_rdy = 1'b1;
    @(posedge clk);
    manual_rdy = 1'b0;
    @(negedge clk);
    check("pulse_in_ready", int'(in_ready), 1);
    check("pulse_out_valid", int'(out_valid), 0);
    manual_mode = 1'b0;

    // Reset in the middle of a full operation aborts it.
    issue(0, pt(8'h00, 8'h02), 0, pt(8'h0D, 8'h07), FULL);
    repeat (25) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_result", int'(result), 0);
    n = 0;
    for (int i = 0; i < 60; i++) begin @(negedge clk); if (out_valid) n++; end
    check("abort_no_valid", n, 0);
    issue(0, pt(8'h00, 8'h02), 0, pt(8'h0D, 8'h07), FULL);

    // Randomized operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      o = int'($urandom_range(0, 1));
      a = int'($urandom_range(0, 16383));
      b = int'($urandom_range(0, 16383));
      case ($urandom_range(0, 7))
        0: b = a;
        1: b = (b & ~MASK) | (a & MASK);
        2: a = 0;
        3: b = 0;
        4: a = a & ~MASK;
        default: ;
      endcase
      issue(o, a, b, ref_op(o, a, b), ref_lat(o, a, b));
    end

    n = 0;
    while ((q.size() != 0 || out_valid) && n < 400) begin @(negedge clk); n++; end
    check("drain_queue", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
